// File: rtl/lif_neuron_scheduler_pkg.sv
// Shared types and reset constants for the time-multiplexed LIF neuron scheduler.
// The refractory reload value is only used when LIF_SCHED_REFRACTORY_EN is defined.
package lif_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2
  } sched_state_e;

  localparam int unsigned DEF_WEIGHT  = 1;
  localparam int unsigned DEF_LEAK    = 1;
  localparam int unsigned DEF_THRESH  = 16;
  localparam logic [1:0]  REFR_RELOAD = 2'd3;

endpackage

// File: rtl/lif_neuron_scheduler_potential_update.sv
// One neuron's membrane update: saturating charge or zero-floored leak,
// followed by the threshold compare on the updated value.
module lif_potential_update #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] v_i,
  input  logic             chg_i,
  input  logic [WIDTH-1:0] weight_i,
  input  logic [WIDTH-1:0] leak_i,
  input  logic [WIDTH-1:0] thresh_i,
  output logic [WIDTH-1:0] v_next_o,
  output logic             fire_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] charged;
  logic [WIDTH-1:0] leaked;

  assign sum     = {1'b0, v_i} + {1'b0, weight_i};
  assign charged = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
  assign leaked  = (v_i > leak_i) ? (v_i - leak_i) : '0;

  assign v_next_o = chg_i ? charged : leaked;
  assign fire_o   = (v_next_o >= thresh_i);

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Round-robin scheduler sharing one LIF update among N_NEURONS virtual neurons;
// spikes leave on a valid/ready port. Define LIF_SCHED_REFRACTORY_EN for refractory counters.
//
// state | meaning
// IDLE  | paused, ptr retained, no service
// SCAN  | servicing neuron ptr this cycle
// EMIT  | spike for neuron ptr offered downstream, ptr frozen
module lif_neuron_scheduler
  import lif_sched_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int N_NEURONS = 4,
  localparam int ID_W      = $clog2(N_NEURONS)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [N_NEURONS-1:0] spike_in_i,
  input  logic                 cfg_we_i,
  input  logic [WIDTH-1:0]     cfg_weight_i,
  input  logic [WIDTH-1:0]     cfg_leak_i,
  input  logic [WIDTH-1:0]     cfg_thresh_i,
  output logic                 spike_out_valid_o,
  output logic [ID_W-1:0]      spike_out_id_o,
  input  logic                 spike_out_ready_i,
  output logic                 sweep_done_o,
  output logic                 busy_o
);

  localparam logic [ID_W-1:0] LAST = ID_W'(N_NEURONS - 1);

  sched_state_e         state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [WIDTH-1:0]     v_q [N_NEURONS];
  logic [WIDTH-1:0]     v_d [N_NEURONS];
  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic                 valid_q, valid_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 sweep_q, sweep_d;
  logic [WIDTH-1:0]     weight_q, leak_q, thresh_q;

  logic             svc, chg, upd_fire, fire, advance;
  logic [WIDTH-1:0] v_upd, v_new;

  // clear pre-empts the visit; ptr then holds so the neuron is serviced next cycle
  assign svc = (state_q == SCAN) && !clear_i;
  assign chg = pending_q[ptr_q] | spike_in_i[ptr_q];

  lif_potential_update #(.WIDTH(WIDTH)) u_update (
    .v_i      (v_q[ptr_q]),
    .chg_i    (chg),
    .weight_i (weight_q),
    .leak_i   (leak_q),
    .thresh_i (thresh_q),
    .v_next_o (v_upd),
    .fire_o   (upd_fire)
  );

`ifdef LIF_SCHED_REFRACTORY_EN
  logic [1:0] refr_q [N_NEURONS];
  logic [1:0] refr_d [N_NEURONS];
  logic       in_refr;

  assign in_refr = (refr_q[ptr_q] != 2'd0);
  assign fire    = upd_fire & ~in_refr;
  assign v_new   = in_refr ? '0 : v_upd;

  always_comb begin
    refr_d = refr_q;
    if (clear_i) begin
      for (int i = 0; i < N_NEURONS; i++) refr_d[i] = '0;
    end else if (svc) begin
      if (in_refr)   refr_d[ptr_q] = refr_q[ptr_q] - 2'd1;
      else if (fire) refr_d[ptr_q] = REFR_RELOAD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < N_NEURONS; i++) refr_q[i] <= '0;
    end else begin
      refr_q <= refr_d;
    end
  end
`else
  assign fire  = upd_fire;
  assign v_new = v_upd;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = SCAN;
      SCAN: begin
        if (svc && fire)    state_d = EMIT;
        else if (!enable_i) state_d = IDLE;
      end
      EMIT:    if (spike_out_ready_i) state_d = enable_i ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    advance = 1'b0;
    valid_d = valid_q;
    id_d    = id_q;
    case (state_q)
      SCAN: begin
        if (svc) begin
          if (fire) begin
            valid_d = 1'b1;
            id_d    = ptr_q;
          end else begin
            advance = 1'b1;
          end
        end
      end
      EMIT: begin
        if (spike_out_ready_i) begin
          valid_d = 1'b0;
          advance = 1'b1;
        end
      end
      default: ;
    endcase
    ptr_d   = advance ? ((ptr_q == LAST) ? '0 : ptr_q + 1'b1) : ptr_q;
    sweep_d = advance && (ptr_q == LAST);

    v_d       = v_q;
    pending_d = pending_q | spike_in_i;
    if (clear_i) begin
      for (int i = 0; i < N_NEURONS; i++) v_d[i] = '0;
      pending_d = spike_in_i;
    end else if (svc) begin
      v_d[ptr_q]       = fire ? '0 : v_new;
      pending_d[ptr_q] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q     <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      sweep_q   <= 1'b0;
      weight_q  <= WIDTH'(DEF_WEIGHT);
      leak_q    <= WIDTH'(DEF_LEAK);
      thresh_q  <= WIDTH'(DEF_THRESH);
      for (int i = 0; i < N_NEURONS; i++) v_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      sweep_q   <= sweep_d;
      v_q       <= v_d;
      if (cfg_we_i) begin
        weight_q <= cfg_weight_i;
        leak_q   <= cfg_leak_i;
        thresh_q <= cfg_thresh_i;
      end
    end
  end

  assign spike_out_valid_o = valid_q;
  assign spike_out_id_o    = id_q;
  assign sweep_done_o      = sweep_q;
  assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Bench for lif_neuron_scheduler: table of single-neuron scenarios plus directed sequences;
// spikes are predicted per visit and matched against the output port through a queue.
module tb_lif_neuron_scheduler;
  import lif_sched_pkg::*;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int VMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n, enable, clear, cfg_we, ready;
  logic [N-1:0] spike_in;
  logic [W-1:0] cfg_weight, cfg_leak, cfg_thresh;
  logic         spike_out_valid, sweep_done, busy;
  logic [1:0]   spike_out_id;

  always #5 clk = ~clk;

  lif_neuron_scheduler #(.WIDTH(W), .N_NEURONS(N)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .enable_i          (enable),
    .clear_i           (clear),
    .spike_in_i        (spike_in),
    .cfg_we_i          (cfg_we),
    .cfg_weight_i      (cfg_weight),
    .cfg_leak_i        (cfg_leak),
    .cfg_thresh_i      (cfg_thresh),
    .spike_out_valid_o (spike_out_valid),
    .spike_out_id_o    (spike_out_id),
    .spike_out_ready_i (ready),
    .sweep_done_o      (sweep_done),
    .busy_o            (busy)
  );

  typedef struct {
    int         n;
    int         w;
    int         l;
    int         th;
    int         nv;
    logic [7:0] pat;
    int         exp_v;
    int         exp_f;
  } vec_t;

  vec_t vecs [9];

  int   tests_run = 0;
  int   tests_failed = 0;
  int   exp_q [$];
  int   obs_q [$];
  bit   sb_off = 1'b0;
  int   hs_count = 0;
  logic prev_v = 1'b0;
  logic prev_r = 1'b0;

  int         mv [N];
  logic [N-1:0] mpend = '0;
  int         mw = 1;
  int         ml = 1;
  int         mth = 16;
`ifdef LIF_SCHED_REFRACTORY_EN
  int         mr [N];
`endif

  function void check(string name, int act, int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference behaviour of one visit to neuron n
  function void model_visit(int n, bit chg);
    int  v;
    bit  c;
    c = chg | mpend[n];
    mpend[n] = 1'b0;
`ifdef LIF_SCHED_REFRACTORY_EN
    if (mr[n] != 0) begin
      mr[n]--;
      mv[n] = 0;
      return;
    end
`endif
    v = mv[n];
    if (c) v = (v + mw > VMAX) ? VMAX : v + mw;
    else   v = (v > ml) ? v - ml : 0;
    if (v >= mth) begin
      exp_q.push_back(n);
      mv[n] = 0;
`ifdef LIF_SCHED_REFRACTORY_EN
      mr[n] = 3;
`endif
    end else begin
      mv[n] = v;
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_v && !prev_r) check("hold_valid", int'(spike_out_valid), 1);
      if (spike_out_valid && ready) begin
        hs_count++;
        if (sb_off) obs_q.push_back(int'(spike_out_id));
        else begin
          check("sb_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("sb_id", int'(spike_out_id), exp_q.pop_front());
        end
      end
      prev_v = spike_out_valid;
      prev_r = ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int w, int l, int th);
    cfg_weight = W'(w);
    cfg_leak   = W'(l);
    cfg_thresh = W'(th);
    cfg_we     = 1'b1;
    tick();
    cfg_we = 1'b0;
    mw = w; ml = l; mth = th;
  endtask

  task automatic do_clear(logic [N-1:0] mask);
    clear    = 1'b1;
    spike_in = mask;
    tick();
    clear    = 1'b0;
    spike_in = '0;
    for (int i = 0; i < N; i++) mv[i] = 0;
`ifdef LIF_SCHED_REFRACTORY_EN
    for (int i = 0; i < N; i++) mr[i] = 0;
`endif
    mpend = mask;
  endtask

  task automatic go_idle();
    int g;
    g = 0;
    enable   = 1'b0;
    spike_in = '0;
    while (busy && g < 20) begin
      tick();
      g++;
    end
    check("go_idle", int'(busy), 0);
  endtask

  // Wait for the cycle that services neuron n, present chg on its strobe then
  task automatic visit(int n, bit chg, bit drop_en);
    int g;
    g = 0;
    while (!(dut.state_q == SCAN && int'(dut.ptr_q) == n) && g < 64) begin
      tick();
      g++;
    end
    if (g >= 64) begin
      check("visit_timeout", g, 0);
      return;
    end
    spike_in[n] = chg;
    if (drop_en) enable = 1'b0;
    tick();
    spike_in = '0;
    model_visit(n, chg);
  endtask

  int k;
  int hs0;

  initial begin
    vecs[0] = '{2,   5,  0,  16, 4, 8'b00001111,   0, 1};
    vecs[1] = '{1,   5,  0,  16, 3, 8'b00000111,  15, 0};
    vecs[2] = '{0, 250,  0, 255, 2, 8'b00000011,   0, 1};
    vecs[3] = '{3,   2,  3,  16, 2, 8'b00000001,   0, 0};
    vecs[4] = '{0,  10,  3, 100, 4, 8'b00000011,  14, 0};
    vecs[5] = '{2, 200, 50, 250, 3, 8'b00000101,   0, 1};
    vecs[6] = '{1,  16,  1,  16, 1, 8'b00000001,   0, 1};
    vecs[7] = '{3, 100,  1, 255, 5, 8'b00000011, 197, 0};
    vecs[8] = '{0,   1,  1,  16, 3, 8'b00000011,   1, 0};

    for (int i = 0; i < N; i++) mv[i] = 0;
`ifdef LIF_SCHED_REFRACTORY_EN
    for (int i = 0; i < N; i++) mr[i] = 0;
`endif

    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; cfg_we = 1'b0; ready = 1'b1;
    spike_in = '0; cfg_weight = '0; cfg_leak = '0; cfg_thresh = '0;
    repeat (3) tick();
    check("rst_valid", int'(spike_out_valid), 0);
    check("rst_id", int'(spike_out_id), 0);
    check("rst_sweep", int'(sweep_done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ptr", int'(dut.ptr_q), 0);
    check("rst_pending", int'(dut.pending_q), 0);
    rst_n = 1'b1;

    // Free run with defaults: one sweep per N cycles, no spikes
    enable = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!sweep_done && k < 20);
    check("sweep_first", k, 5);
    for (int s = 0; s < 3; s++) begin
      k = 0;
      do begin tick(); k++; end while (!sweep_done && k < 20);
      check($sformatf("sweep_period%0d", s), k, 4);
    end
    for (int i = 0; i < N; i++) check($sformatf("idle_v%0d", i), int'(dut.v_q[i]), 0);

    // Default weight 1 / thresh 16: fires on the 16th charge
    for (int j = 0; j < 15; j++) visit(0, 1'b1, 1'b0);
    check("def_v15", int'(dut.v_q[0]), 15);
    visit(0, 1'b1, 1'b0);
    check("def_fire_v", int'(dut.v_q[0]), 0);

    for (int r = 0; r < 9; r++) begin
      go_idle();
      cfg(vecs[r].w, vecs[r].l, vecs[r].th);
      do_clear('0);
      hs0 = hs_count;
      enable = 1'b1;
      for (int j = 0; j < vecs[r].nv; j++) visit(vecs[r].n, vecs[r].pat[j], 1'b0);
      check($sformatf("vec%0d_v", r), int'(dut.v_q[vecs[r].n]), vecs[r].exp_v);
      go_idle();
      check($sformatf("vec%0d_fires", r), hs_count - hs0, vecs[r].exp_f);
    end

    // Backpressure: spike from neuron 1 held for 10 cycles
    go_idle();
    cfg(16, 0, 16);
    do_clear('0);
    ready  = 1'b0;
    enable = 1'b1;
    visit(1, 1'b1, 1'b0);
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", int'(spike_out_valid), 1);
      check("bp_id", int'(spike_out_id), 1);
      check("bp_ptr", int'(dut.ptr_q), 1);
      if (c == 3) spike_in[3] = 1'b1;
      tick();
      spike_in = '0;
    end
    mpend[3] = 1'b1;
    check("bp_pending3", int'(dut.pending_q[3]), 1);
    ready = 1'b1;
    tick();
    check("bp_valid_drop", int'(spike_out_valid), 0);
    check("bp_ptr_adv", int'(dut.ptr_q), 2);
    visit(3, 1'b0, 1'b0);

    // sweep_done after a handshake on the last neuron
    go_idle();
    cfg(16, 0, 16);
    do_clear('0);
    enable = 1'b1;
    visit(3, 1'b1, 1'b0);
    check("emit3_valid", int'(spike_out_valid), 1);
    check("emit3_id", int'(spike_out_id), 3);
    check("emit3_sweep_early", int'(sweep_done), 0);
    tick();
    check("emit3_sweep", int'(sweep_done), 1);
    check("emit3_valid_drop", int'(spike_out_valid), 0);

    // clear with a simultaneous spike on neuron 0
    go_idle();
    cfg(5, 0, 16);
    do_clear('0);
    enable = 1'b1;
    visit(0, 1'b1, 1'b0);
    check("preclr_v0", int'(dut.v_q[0]), 5);
    go_idle();
    do_clear(4'b0001);
    for (int i = 0; i < N; i++) check($sformatf("clr_v%0d", i), int'(dut.v_q[i]), 0);
    check("clr_pending", int'(dut.pending_q), 1);
    enable = 1'b1;
    visit(0, 1'b0, 1'b0);
    check("clr_charge_v0", int'(dut.v_q[0]), 5);

    // enable dropped during a service: the visit still lands, then IDLE
    visit(2, 1'b1, 1'b1);
    check("endrop_busy", int'(busy), 0);
    check("endrop_v2", int'(dut.v_q[2]), 5);

    // Behaviour on visits right after a fire
    go_idle();
    cfg(8, 0, 16);
    do_clear('0);
    enable = 1'b1;
    visit(1, 1'b1, 1'b0);
    visit(1, 1'b1, 1'b0);
    check("refire_v0", int'(dut.v_q[1]), 0);
`ifdef LIF_SCHED_REFRACTORY_EN
    for (int j = 0; j < 3; j++) begin
      visit(1, 1'b1, 1'b0);
      check($sformatf("refr_v%0d", j), int'(dut.v_q[1]), 0);
    end
`endif
    visit(1, 1'b1, 1'b0);
    check("resume_v", int'(dut.v_q[1]), 8);

`ifndef LIF_SCHED_REFRACTORY_EN
    // thresh 0: every visit fires, ids follow the round robin
    go_idle();
    cfg(1, 1, 0);
    do_clear('0);
    obs_q.delete();
    sb_off = 1'b1;
    enable = 1'b1;
    repeat (20) tick();
    go_idle();
    sb_off = 1'b0;
    check("thr0_count", int'(obs_q.size() >= 8), 1);
    for (int i = 1; i < obs_q.size(); i++)
      check($sformatf("thr0_order%0d", i), obs_q[i], (obs_q[i-1] + 1) % N);
`endif

    go_idle();
    check("sb_drained", int'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit, tests run %0d", tests_run);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lif_neuron_scheduler.md
Name: lif_neuron_scheduler

Overview:
Time-multiplexed controller that shares one LIF update datapath among N_NEURONS virtual neurons. Membrane potentials live in an internal register array, and neurons are serviced round-robin at one per cycle.
- Each neuron visit either charges (pending input spike) or leaks, then checks the threshold.
- Output spikes leave through a valid/ready port tagged with the neuron ID.
- The block sits between the input spike fabric and downstream spike routing.

Parameters:
WIDTH, 8, membrane potential / weight / leak / threshold width
N_NEURONS, 4, number of virtual neurons (>=2)
ID_W, $clog2(N_NEURONS), neuron ID width (derived; not overridden)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
enable  in  1  run scheduler; low = pause after any pending handshake completes
clear  in  1  synchronous: zero all potentials and pending bits
spike_in  in  N_NEURONS  per-neuron input spike strobes, one cycle each
cfg_we  in  1  latch cfg_* values
cfg_weight  in  WIDTH  charge increment
cfg_leak  in  WIDTH  leak decrement
cfg_thresh  in  WIDTH  firing threshold
spike_out_valid  out  1  output spike available
spike_out_id  out  ID_W  neuron that fired
spike_out_ready  in  1  downstream accepts spike
sweep_done  out  1  one-cycle pulse when neuron N_NEURONS-1 has been serviced
busy  out  1  state != IDLE

Behaviour:
- Reset (async): state=IDLE; ptr=0; all potentials=0; pending=0; spike_out_valid=0; spike_out_id=0; sweep_done=0; weight=1; leak=1; thresh=8'd16 (scaled as 16 for any WIDTH).
- Config: when cfg_we=1, the three cfg registers update at the clock edge and take effect from the next cycle's service.
- Pending capture: pending[i] is set on any cycle with spike_in[i]=1, in every state.
- FSM states: IDLE, SCAN, EMIT.
  - IDLE: enable=1 goes to SCAN next cycle; ptr is retained.
  - SCAN: each cycle services neuron ptr.
  - EMIT: spike_out_valid=1 and ptr is frozen. When spike_out_ready=1, spike_out_valid drops next cycle, ptr advances, and the next state is SCAN if enable=1, otherwise IDLE.
- Service of neuron ptr:
  - chg = pending[ptr] | spike_in[ptr]. A simultaneous arrival is consumed by this visit, and pending[ptr] clears.
  - If chg: V' = min(V + weight, 2^WIDTH-1), saturating.
  - Else: V' = (V > leak) ? V - leak : 0, floored at zero.
  - If V' >= thresh: V stores 0, spike_out_valid=1 and spike_out_id=ptr on the next edge, and the state moves to EMIT with ptr held. Otherwise V stores V' and ptr advances.
  - thresh=0: every visited neuron fires on every visit.
- Pointer: wraps N_NEURONS-1 to 0. sweep_done pulses the cycle after ptr advances from N_NEURONS-1; in EMIT it pulses after the handshake.
- enable deasserted in SCAN: the state goes to IDLE next cycle, and the in-flight service still completes.
- enable deasserted in EMIT: the handshake is held until ready.
- clear: has priority over service. It zeroes potentials and pending, but spike_in in the same cycle is still captured afterwards, i.e. pending = spike_in. It does not alter state, ptr or an outstanding spike_out_valid.
- Valid/ready: spike_out_valid and spike_out_id are stable until the handshake. Valid never drops without ready.

Optional Feature:
Macro LIF_SCHED_REFRACTORY_EN.
- Defined: a per-neuron 2-bit refractory counter is loaded with 3 when the neuron fires. On each later visit the counter decrements instead of charging, and the potential is forced to 0. Input spikes arriving during refractory are discarded (pending cleared).
- Undefined: no counters; a neuron may charge on the visit after it fires.

Decomposition:
- Package lif_sched_pkg: FSM state enum (IDLE=2'd0, SCAN=2'd1, EMIT=2'd2), reset defaults for weight, leak and thresh, and the refractory reload constant.
- Sub-module lif_potential_update: combinational saturating charge, floored leak and threshold compare for one neuron. Inputs V, chg, weight, leak, thresh; outputs V_next and fire.

Test Plan:
- Reset, enable=1, no spikes, defaults -> all potentials stay 0, no spike_out_valid, sweep_done every 4 cycles.
- weight=5, thresh=16, leak=0, spike_in[2] on each of its visits -> neuron 2 fires on its 4th visit (20>=16), spike_out_id=2, potential then 0.
- Spike pending on neuron 1, spike_out_ready=0 for 10 cycles -> valid held with id=1, ptr frozen, new spike_in captured; ready=1 -> valid drops next cycle, ptr=2.
- weight=250, WIDTH=8, thresh=255, two charges -> saturates at 255 and fires; leak=3 from V=2 -> 0, not wrap.
- clear asserted with spike_in[0] same cycle -> all potentials 0, pending=4'b0001, neuron 0 charges on next visit.
- LIF_SCHED_REFRACTORY_EN defined: neuron fires, then spike_in every visit -> 3 visits at V=0, charging resumes on the 4th.
